// File: rtl/if_fetch_unit.sv
// IF stage: holds the PC, issues in-order imem requests, queues {pc,instr} for IF/ID (head visible the cycle after imem_rsp_valid).
// Requests stop while outstanding + dropping + queued reaches FIFO_DEPTH; stall_d holds the head and all outputs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INSTR_NOP  = 32'h0000_0013,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        fetch_valid,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] dq_cnt;
  logic [AW-1:0] aq_wr, aq_rd, dq_wr, dq_rd;
  logic [31:0]   aq_mem [FIFO_DEPTH];
  fetch_ent_t    dq_mem [FIFO_DEPTH];
  logic [CW:0]   inflight;
  logic          hs, rsp_take, rsp_drop, consume;
  fetch_ent_t    head;

  // Address queue depth always equals outstanding, so outstanding doubles as its count.
  assign inflight       = {1'b0, outstanding} + {1'b0, drop} + {1'b0, dq_cnt};
  assign imem_req_valid = !rst && !redirect_valid && (inflight < DEPTH_C);
  assign imem_req_addr  = pc;
  assign hs             = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (drop == '0);
  assign rsp_drop       = imem_rsp_valid && (drop != '0);

  assign head        = dq_mem[dq_rd];
  assign fetch_valid = !rst && (dq_cnt != '0);
  assign consume     = fetch_valid && !stall_d;
  assign instr_f     = fetch_valid ? head.instr : INSTR_NOP;
  assign pc_f        = fetch_valid ? head.pc : '0;
  assign pc_plus4_f  = fetch_valid ? head.pc + 32'd4 : '0;

  always_ff @(posedge clk) begin
    if (hs) aq_mem[aq_wr] <= pc;
    if (rsp_take && !redirect_valid && !rst) dq_mem[dq_wr] <= {aq_mem[aq_rd], imem_rsp_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      dq_cnt      <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
      dq_wr       <= '0;
      dq_rd       <= '0;
    end else if (redirect_valid) begin
      // Every in-flight word is now stale; a response landing this cycle is one of them.
      pc          <= redirect_pc & ~32'd3;
      drop        <= drop + outstanding - CW'(imem_rsp_valid);
      outstanding <= '0;
      dq_cnt      <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
      dq_wr       <= '0;
      dq_rd       <= '0;
    end else begin
      if (hs) pc <= pc + 32'd4;
      outstanding <= outstanding + CW'(hs) - CW'(rsp_take);
      drop        <= drop - CW'(rsp_drop);
      dq_cnt      <= dq_cnt + CW'(rsp_take) - CW'(consume);
      aq_wr       <= aq_wr + AW'(hs);
      aq_rd       <= aq_rd + AW'(rsp_take);
      dq_wr       <= dq_wr + AW'(rsp_take);
      dq_rd       <= dq_rd + AW'(consume);
    end
  end

  a_rsp_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0 || drop != '0));
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, outstanding} <= DEPTH_C) && ({1'b0, drop} <= DEPTH_C) && ({1'b0, dq_cnt} <= DEPTH_C));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-configurable in-order memory model.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        fetch_valid;
  logic [31:0] instr_f, pc_f, pc_plus4_f;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  int          lat      = 1;
  logic [31:0] exp_req, exp_pc;
  logic        pv [8];
  logic [31:0] pa [8];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_d(stall_d),
    .fetch_valid(fetch_valid), .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) | 32'h0000_0003;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // One clock: log the handshake, then advance the memory pipeline.
  task automatic tick();
    logic        hs;
    logic        r;
    logic [31:0] a;
    #1;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    r  = rst;
    if (hs) begin
      check_eq("req_addr", a, exp_req);
      exp_req = exp_req + 32'd4;
      hs_cnt++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pa[i] = pa[i+1];
    end
    pv[7] = 1'b0;
    if (r) begin
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    end else if (hs) begin
      pv[lat-1] = 1'b1;
      pa[lat-1] = a;
    end
    imem_rsp_valid = pv[0];
    imem_rsp_data  = pv[0] ? memw(pa[0]) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (fetch_valid && !stall_d) begin
        check_eq("head_pc", pc_f, exp_pc);
        check_eq("head_instr", instr_f, memw(exp_pc));
        check_eq("head_pc4", pc_plus4_f, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end else if (!fetch_valid) begin
        check_eq("bubble_instr", instr_f, 32'h0000_0013);
        check_eq("bubble_pc", pc_f, 0);
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    stall_d = 1'b0;
    #1;
    check_eq("rst_cycle_fv", 32'(fetch_valid), 0);
    check_eq("rst_cycle_req", 32'(imem_req_valid), 0);
    check_eq("rst_cycle_instr", instr_f, 32'h0000_0013);
    tick();
    check_eq("rst_fv", 32'(fetch_valid), 0);
    check_eq("rst_pc4", pc_plus4_f, 0);
    tick();
    rst = 1'b0;
    exp_req = 32'h0;
    exp_pc  = 32'h0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
    exp_req = '0; exp_pc = '0;
    for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pa[i] = '0; end

    // 1: streaming after reset, 1-cycle memory
    lat = 1;
    do_reset();
    check_eq("t1_req_vld", 32'(imem_req_valid), 1);
    check_eq("t1_req_addr", imem_req_addr, 32'h0);
    check_eq("t1_fv_c1", 32'(fetch_valid), 0);
    tick();
    check_eq("t1_fv_c2", 32'(fetch_valid), 0);
    tick();
    check_eq("t1_fv_c3", 32'(fetch_valid), 1);
    check_eq("t1_pc_c3", pc_f, 32'h0);
    check_eq("t1_instr_c3", instr_f, memw(32'h0));
    check_eq("t1_credit_c3", 32'(imem_req_valid), 0);
    run(20);
    check_eq("t1_progress", 32'(exp_pc >= 32'h30), 1);

    // 2: stall holds head, credit caps requests
    for (int k = 0; k < 10 && !fetch_valid; k++) tick();
    check_eq("t2_wait_fv", 32'(fetch_valid), 1);
    stall_d = 1'b1;
    hs0 = hs_cnt;
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_hold_pc", pc_f, exp_pc);
      check_eq("t2_hold_instr", instr_f, memw(exp_pc));
      tick();
    end
    check_eq("t2_stall_reqs", 32'((hs_cnt - hs0) <= 2), 1);
    check_eq("t2_req_off", 32'(imem_req_valid), 0);
    check_eq("t2_fv", 32'(fetch_valid), 1);
    stall_d = 1'b0;
    hs0 = int'(exp_pc);
    run(20);
    check_eq("t2_progress", 32'(exp_pc >= 32'(hs0) + 32'h20), 1);

    // 4: ready low holds the request address
    imem_req_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h10; exp_req = 32'h10; exp_pc = 32'h10;
    #1;
    check_eq("t4_req_supp", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("t4_addr_hold", imem_req_addr, 32'h10);
      check_eq("t4_req_vld", 32'(imem_req_valid), 1);
      tick();
    end
    check_eq("t4_addr_final", imem_req_addr, 32'h10);
    imem_req_ready = 1'b1;
    #1;
    run(12);
    check_eq("t4_progress", 32'(exp_pc >= 32'h18), 1);

    // 3: redirect with two 3-cycle responses in flight
    lat = 3;
    do_reset();
    tick();
    tick();
    check_eq("t3_credit_full", 32'(imem_req_valid), 0);
    redirect_valid = 1'b1; redirect_pc = 32'h103; exp_req = 32'h100; exp_pc = 32'h100;
    #1;
    check_eq("t3_req_supp", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t3_fv_e3", 32'(fetch_valid), 0);
    check_eq("t3_req_e3", 32'(imem_req_valid), 0);
    tick();
    check_eq("t3_req_e4", 32'(imem_req_valid), 1);
    check_eq("t3_addr_e4", imem_req_addr, 32'h100);
    check_eq("t3_fv_e4", 32'(fetch_valid), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t3_fv_empty", 32'(fetch_valid), 0);
    end
    tick();
    check_eq("t3_fv_e8", 32'(fetch_valid), 1);
    check_eq("t3_pc_e8", pc_f, 32'h100);
    check_eq("t3_instr_e8", instr_f, memw(32'h100));
    run(10);

    // 5: redirect + response + consume in one cycle
    lat = 1;
    do_reset();
    tick();
    tick();
    check_eq("t5_fv_pre", 32'(fetch_valid), 1);
    check_eq("t5_rsp_pre", 32'(imem_rsp_valid), 1);
    redirect_valid = 1'b1; redirect_pc = 32'h200; exp_req = 32'h200; exp_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t5_fv", 32'(fetch_valid), 0);
    check_eq("t5_instr", instr_f, 32'h0000_0013);
    check_eq("t5_pc", pc_f, 0);
    check_eq("t5_pc4", pc_plus4_f, 0);
    check_eq("t5_req_vld", 32'(imem_req_valid), 1);
    check_eq("t5_req_addr", imem_req_addr, 32'h200);

    // 6: PC wrap, then reset mid-stream
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; exp_req = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    check_eq("t6_req_top", 32'(imem_req_valid), 1);
    tick();
    check_eq("t6_addr_wrap", imem_req_addr, 32'h0);
    check_eq("t6_req_wrap", 32'(imem_req_valid), 1);
    run(6);
    check_eq("t6_wrapped", 32'(exp_pc < 32'h100), 1);
    do_reset();
    check_eq("t6_post_fv", 32'(fetch_valid), 0);
    check_eq("t6_post_req", 32'(imem_req_valid), 1);
    check_eq("t6_post_addr", imem_req_addr, 32'h0);
    run(8);
    check_eq("t6_post_progress", 32'(exp_pc >= 32'h8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
